// File: rtl/input_arbiter.sv
// Multi-player answer arbiter: synchronize, debounce, round-robin into a FIFO.
// Optional INPUT_LOCKOUT_EN adds lock_clr and per-player lockout after a push.
module input_arbiter #(
  parameter int NPLAYERS        = 4,
  parameter int DEBOUNCE_CYCLES = 1000,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [8*NPLAYERS-1:0] gpio_data,
  input  logic [NPLAYERS-1:0]   gpio_strobe,
  input  logic                  rd_en,
`ifdef INPUT_LOCKOUT_EN
  input  logic                  lock_clr,
`endif
  output logic [15:0]           rd_data,
  output logic [3:0]            fifo_count,
  output logic                  irq,
  output logic                  overflow
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] CMAX = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [3:0] FULLC = 4'(FIFO_DEPTH);

  logic [NPLAYERS-1:0]   s1_stb, s2_stb;
  logic [8*NPLAYERS-1:0] s1_dat, s2_dat;
  logic [CW-1:0]         cnt [NPLAYERS];
  logic [NPLAYERS-1:0]   deb, deb_q, press_r;

  logic [NPLAYERS-1:0]   pend;
  logic [7:0]            pdat [NPLAYERS];
  logic [NPLAYERS-1:0]   locked, acc, take;
  logic [1:0]            rr, gnt;
  logic                  gnt_v;

  logic [9:0]            mem [FIFO_DEPTH];
  logic [AW-1:0]         wp, rp;
  logic                  full, empty, push, pop;

  // Synchronizers and per-player debounce counters
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_stb  <= '0;
      s2_stb  <= '0;
      s1_dat  <= '0;
      s2_dat  <= '0;
      deb     <= '0;
      deb_q   <= '0;
      press_r <= '0;
      for (int p = 0; p < NPLAYERS; p++) cnt[p] <= '0;
    end else begin
      s1_stb  <= gpio_strobe;
      s2_stb  <= s1_stb;
      s1_dat  <= gpio_data;
      s2_dat  <= s1_dat;
      deb_q   <= deb;
      press_r <= deb & ~deb_q;
      for (int p = 0; p < NPLAYERS; p++) begin
        if (s2_stb[p] == deb[p]) begin
          cnt[p] <= '0;
        end else if (cnt[p] == CMAX) begin
          cnt[p] <= '0;
          deb[p] <= s2_stb[p];
        end else begin
          cnt[p] <= cnt[p] + CW'(1);
        end
      end
    end
  end

  // Round-robin: the lowest offset from rr wins, so scan downward
  always_comb begin
    gnt_v = 1'b0;
    gnt   = '0;
    for (int i = NPLAYERS - 1; i >= 0; i--) begin
      if (pend[(int'(rr) + i) % NPLAYERS]) begin
        gnt_v = 1'b1;
        gnt   = 2'((int'(rr) + i) % NPLAYERS);
      end
    end
  end

  assign empty = (fifo_count == 4'd0);
  assign full  = (fifo_count == FULLC);
  assign pop   = rd_en && !empty;
  assign push  = gnt_v && (!full || pop);

  always_comb begin
    take = '0;
    for (int p = 0; p < NPLAYERS; p++) begin
      take[p] = push && (int'(gnt) == p);
    end
  end

  assign acc = press_r & ~locked;

`ifdef INPUT_LOCKOUT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      locked <= '0;
    end else if (lock_clr) begin
      locked <= '0;
    end else begin
      locked <= locked | take;
    end
  end
`else
  assign locked = '0;
`endif

  // A slot freed by this cycle's push may accept a same-cycle press
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend     <= '0;
      rr       <= '0;
      overflow <= 1'b0;
      for (int p = 0; p < NPLAYERS; p++) pdat[p] <= '0;
    end else begin
      for (int p = 0; p < NPLAYERS; p++) begin
        if (acc[p] && (!pend[p] || take[p])) begin
          pend[p] <= 1'b1;
          pdat[p] <= s2_dat[8*p +: 8];
        end else if (take[p]) begin
          pend[p] <= 1'b0;
        end
      end
      if (|(acc & pend & ~take)) overflow <= 1'b1;
      if (push) rr <= 2'((int'(gnt) + 1) % NPLAYERS);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wp] <= {gnt, pdat[gnt]};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wp         <= '0;
      rp         <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wp <= wp + AW'(1);
      if (pop)  rp <= rp + AW'(1);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 4'd1;
        2'b01:   fifo_count <= fifo_count - 4'd1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  assign rd_data = empty ? 16'h0000 : {1'b1, 5'b0, mem[rp]};
  assign irq     = !empty;

endmodule

// File: tb/tb_input_arbiter.sv
// Directed bench for input_arbiter: latency, debounce, round-robin,
// FIFO full/overflow, reset, and lockout when INPUT_LOCKOUT_EN is set.
module tb_input_arbiter;

  localparam int N = 4;
  localparam int D = 8;
  localparam int DEPTH = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [8*N-1:0] gpio_data = '0;
  logic [N-1:0] gpio_strobe = '0;
  logic         rd_en = 1'b0;
`ifdef INPUT_LOCKOUT_EN
  logic         lock_clr = 1'b0;
`endif
  logic [15:0]  rd_data;
  logic [3:0]   fifo_count;
  logic         irq;
  logic         overflow;

  int n_cmp = 0;
  int n_bad = 0;

  input_arbiter #(
    .NPLAYERS(N),
    .DEBOUNCE_CYCLES(D),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .gpio_data(gpio_data),
    .gpio_strobe(gpio_strobe),
    .rd_en(rd_en),
`ifdef INPUT_LOCKOUT_EN
    .lock_clr(lock_clr),
`endif
    .rd_data(rd_data),
    .fifo_count(fifo_count),
    .irq(irq),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs,
                     input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input int p, input logic [7:0] b);
    gpio_data[8*p +: 8] = b;
    gpio_strobe[p] = 1'b1;
    tick(D + 8);
    gpio_strobe[p] = 1'b0;
    tick(D + 8);
  endtask

  task automatic pop1();
    rd_en = 1'b1;
    tick(1);
    rd_en = 1'b0;
  endtask

  task automatic do_reset();
    #2 rst = 1'b0;
    #3 rst = 1'b1;
    tick(2);
  endtask

  initial begin
    // reset state
    #1;
    chk("rst_rd_data", rd_data, 16'h0);
    chk("rst_count", 16'(fifo_count), 16'd0);
    chk("rst_irq", 16'(irq), 16'd0);
    chk("rst_ovf", 16'(overflow), 16'd0);
    tick(1);
    rst = 1'b1;
    tick(2);

    // lone press latency and long hold
    gpio_data[7:0] = 8'hC3;
    gpio_strobe[0] = 1'b1;
    tick(D + 4);
    chk("lat_early", rd_data, 16'h0);
    tick(1);
    chk("lat_exact", rd_data, 16'h80C3);
    tick(10000 - (D + 5));
    chk("hold_count", 16'(fifo_count), 16'd1);
    chk("hold_data", rd_data, 16'h80C3);
    chk("hold_irq", 16'(irq), 16'd1);
    gpio_strobe[0] = 1'b0;
    tick(D + 8);
    pop1();
    chk("pop_data", rd_data, 16'h0);
    chk("pop_irq", 16'(irq), 16'd0);
    chk("pop_count", 16'(fifo_count), 16'd0);

    // short glitch rejected
    gpio_data[15:8] = 8'h99;
    gpio_strobe[1] = 1'b1;
    tick(D - 1);
    gpio_strobe[1] = 1'b0;
    tick(3 * D);
    chk("glitch_count", 16'(fifo_count), 16'd0);
    chk("glitch_ovf", 16'(overflow), 16'd0);

    // simultaneous presses from rr=0
    do_reset();
    gpio_data = 32'h13121110;
    gpio_strobe = 4'hF;
    tick(D + 8);
    gpio_strobe = 4'h0;
    tick(D + 8);
    chk("rr_count", 16'(fifo_count), 16'd4);
    chk("rr_0", rd_data, 16'h8010);
    pop1();
    chk("rr_1", rd_data, 16'h8111);
    pop1();
    chk("rr_2", rd_data, 16'h8212);
    pop1();
    chk("rr_3", rd_data, 16'h8313);
    pop1();
    chk("rr_empty", 16'(fifo_count), 16'd0);
    pop1();
    chk("rr_pop_empty", 16'(fifo_count), 16'd0);

    // full FIFO, pending, overflow
    press(0, 8'hA0);
    press(0, 8'hA1);
    press(0, 8'hA2);
    press(0, 8'hA3);
    chk("full_count", 16'(fifo_count), 16'd4);
    press(0, 8'hA4);
    chk("full_pend_count", 16'(fifo_count), 16'd4);
    chk("full_pend_ovf", 16'(overflow), 16'd0);
    press(0, 8'hA5);
    chk("full_ovf", 16'(overflow), 16'd1);
    chk("full_head", rd_data, 16'h80A0);
    pop1();
    chk("pushpop_count", 16'(fifo_count), 16'd4);
    chk("pushpop_head", rd_data, 16'h80A1);
    pop1();
    pop1();
    pop1();
    chk("pend_entry", rd_data, 16'h80A4);
    pop1();
    chk("drain_count", 16'(fifo_count), 16'd0);

    // reset mid-debounce with entries queued
    press(1, 8'h55);
    press(2, 8'h66);
    chk("q2_count", 16'(fifo_count), 16'd2);
    gpio_strobe[3] = 1'b1;
    tick(D / 2);
    #2 rst = 1'b0;
    #1;
    chk("mid_rd_data", rd_data, 16'h0);
    chk("mid_count", 16'(fifo_count), 16'd0);
    chk("mid_irq", 16'(irq), 16'd0);
    chk("mid_ovf", 16'(overflow), 16'd0);
    gpio_strobe[3] = 1'b0;
    #3 rst = 1'b1;
    tick(3 * D);
    chk("post_count", 16'(fifo_count), 16'd0);
    chk("post_data", rd_data, 16'h0);

    // strobe held through reset release
    gpio_data[23:16] = 8'h5A;
    gpio_strobe[2] = 1'b1;
    tick(D + 8);
    do_reset();
    tick(D + 8);
    chk("held_count", 16'(fifo_count), 16'd1);
    chk("held_data", rd_data, 16'h825A);
    tick(3 * D);
    chk("held_once", 16'(fifo_count), 16'd1);
    gpio_strobe[2] = 1'b0;
    tick(D + 8);
    pop1();

`ifdef INPUT_LOCKOUT_EN
    // lockout
    press(2, 8'h77);
    press(2, 8'h78);
    chk("lock_count", 16'(fifo_count), 16'd1);
    chk("lock_ovf", 16'(overflow), 16'd0);
    chk("lock_data", rd_data, 16'h8277);
    pop1();
    lock_clr = 1'b1;
    tick(1);
    lock_clr = 1'b0;
    press(2, 8'h79);
    chk("unlock_count", 16'(fifo_count), 16'd1);
    chk("unlock_data", rd_data, 16'h8279);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
